// File: rtl/floating_subtract_seq.sv
// Multi-cycle single-precision subtractor (A - B) with one-bit-per-clock alignment
// and normalization, valid/ready handshakes on both sides, truncating rounding.
module floating_subtract_seq #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned MAX_ALIGN = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             underflow,
   output logic             busy
);

   localparam int unsigned MW = 24;
   localparam int unsigned EW = 10;
   localparam int unsigned FW = 23;

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

   state_t               state;
   logic                 sign_l;
   logic                 sign_s;
   logic signed [EW-1:0] exp_q;
   logic [7:0]           diff;
   logic [MW-1:0]        ml;
   logic [MW-1:0]        ms;
   logic [MW-1:0]        m;
   logic                 carry;

   // Operand ordering: B is sign-flipped so the datapath only ever adds magnitudes.
   logic [WIDTH-1:0] b_neg_c;
   logic             a_larger_c;
   logic [WIDTH-1:0] lg_c;
   logic [WIDTH-1:0] sm_c;

   assign b_neg_c    = {~B[WIDTH-1], B[WIDTH-2:0]};
   assign a_larger_c = (A[30:23] > b_neg_c[30:23]) ||
                       ((A[30:23] == b_neg_c[30:23]) && (A[22:0] >= b_neg_c[22:0]));
   assign lg_c       = a_larger_c ? A : b_neg_c;
   assign sm_c       = a_larger_c ? b_neg_c : A;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sign_l    <= 1'b0;
         sign_s    <= 1'b0;
         exp_q     <= '0;
         diff      <= '0;
         ml        <= '0;
         ms        <= '0;
         m         <= '0;
         carry     <= 1'b0;
         result    <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign_l    <= lg_c[WIDTH-1];
                  sign_s    <= sm_c[WIDTH-1];
                  exp_q     <= EW'({2'b00, lg_c[30:23]});
                  diff      <= 8'(lg_c[30:23] - sm_c[30:23]);
                  ml        <= {1'b1, lg_c[FW-1:0]};
                  ms        <= {1'b1, sm_c[FW-1:0]};
                  overflow  <= 1'b0;
                  underflow <= 1'b0;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
                  state     <= ALIGN;
               end
            end
            ALIGN: begin
               if (diff == 8'd0) begin
                  state <= ADD;
               end else if (diff >= 8'(MAX_ALIGN)) begin
                  ms   <= '0;
                  diff <= 8'd0;
               end else begin
                  ms   <= ms >> 1;
                  diff <= diff - 8'd1;
               end
            end
            ADD: begin
               if (sign_l == sign_s) begin
                  {carry, m} <= {1'b0, ml} + {1'b0, ms};
               end else begin
                  carry <= 1'b0;
                  m     <= ml - ms;
               end
               state <= NORM;
            end
            NORM: begin
               if (carry) begin
                  m     <= {1'b1, m[MW-1:1]};
                  exp_q <= exp_q + 10'sd1;
                  carry <= 1'b0;
               end else if (m == '0) begin
                  result    <= '0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (m[MW-1]) begin
                  if (exp_q >= 10'sd255) begin
                     result   <= {sign_l, 8'hFF, 23'h0};
                     overflow <= 1'b1;
                  end else begin
                     result <= {sign_l, exp_q[7:0], m[FW-1:0]};
                  end
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (exp_q <= 10'sd1) begin
                  // One more shift would push the exponent below the normal range.
                  result    <= '0;
                  underflow <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  m     <= m << 1;
                  exp_q <= exp_q - 10'sd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_floating_subtract_seq.sv
// Bench for floating_subtract_seq: directed cases plus random operands checked
// against an arithmetic reference model, including result latency.
module tb_floating_subtract_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        overflow;
   logic        underflow;
   logic        busy;

   int checks;
   int failures;

   floating_subtract_seq #(.WIDTH(32), .MAX_ALIGN(24)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow),
      .underflow (underflow),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference: real-valued magnitudes as integers, rules applied arithmetically.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic ov,
                                 output logic uf, output int lat);
      logic [31:0] bn;
      longint      ka, kb, ml, ms, s;
      int          el, es, d, al, n, e;
      logic        sl, ss;
      bn = b ^ 32'h8000_0000;
      ka = longint'(a[30:23]) * 64'd16777216 + 64'd8388608 + longint'(a[22:0]);
      kb = longint'(bn[30:23]) * 64'd16777216 + 64'd8388608 + longint'(bn[22:0]);
      if (ka >= kb) begin
         el = int'(a[30:23]);  es = int'(bn[30:23]);
         ml = 64'd8388608 + longint'(a[22:0]);  ms = 64'd8388608 + longint'(bn[22:0]);
         sl = a[31];  ss = bn[31];
      end else begin
         el = int'(bn[30:23]); es = int'(a[30:23]);
         ml = 64'd8388608 + longint'(bn[22:0]); ms = 64'd8388608 + longint'(a[22:0]);
         sl = bn[31]; ss = a[31];
      end
      d = el - es;
      if (d >= 24) begin
         ms = 0; al = 1;
      end else begin
         ms = ms / (64'd1 << d); al = d;
      end
      s  = (sl == ss) ? ml + ms : ml - ms;
      e  = el;
      n  = 0;
      ov = 1'b0;
      uf = 1'b0;
      if (s >= 64'd16777216) begin
         s = s / 2; e = e + 1; n = 1;
      end else if (s != 0) begin
         while (s < 64'd8388608) begin
            if (e - 1 < 1) begin
               uf = 1'b1;
               break;
            end
            s = s * 2; e = e - 1; n = n + 1;
         end
      end
      if (s == 0 || uf)   r = 32'h0;
      else if (e >= 255) begin
         r = {sl, 8'hFF, 23'h0}; ov = 1'b1;
      end else            r = {sl, 8'(e), 23'(s)};
      lat = 3 + al + n;
   endfunction

   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      A = a; B = b; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic take_result(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check({tag, "_ov_clear"}, 32'(out_valid), 32'd0);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   task automatic run_and_check(input string tag, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] er;
      logic        eo, eu;
      int          el, lat;
      model(a, b, er, eo, eu, el);
      start_op(a, b);
      wait_result(lat);
      check({tag, "_result"}, result, er);
      check({tag, "_overflow"}, 32'(overflow), 32'(eo));
      check({tag, "_underflow"}, 32'(underflow), 32'(eu));
      check({tag, "_latency"}, 32'(lat), 32'(el));
      take_result(tag);
   endtask

   initial begin
      logic [31:0] held;
      logic [31:0] ra, rb;
      int          lat;
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A         = '0;
      B         = '0;
      #12;
      check("rst_result", result, 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_flags", {30'd0, overflow, underflow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // T1: latency and result against constants
      start_op(32'h4040_0000, 32'h3F80_0000);
      check("t1_busy", 32'(busy), 32'd1);
      wait_result(lat);
      check("t1_result", result, 32'h4000_0000);
      check("t1_latency", 32'(lat), 32'd4);
      take_result("t1");

      // T2: exact cancellation and carry path
      start_op(32'h3F80_0000, 32'h3F80_0000);
      wait_result(lat);
      check("t2a_result", result, 32'h0);
      check("t2a_flags", {30'd0, overflow, underflow}, 32'd0);
      take_result("t2a");
      start_op(32'h3F80_0000, 32'hBF80_0000);
      wait_result(lat);
      check("t2b_result", result, 32'h4000_0000);
      take_result("t2b");

      // T3: long normalization
      start_op(32'h3F80_0000, 32'h3F7F_FFFF);
      wait_result(lat);
      check("t3_result", result, 32'h3400_0000);
      check("t3_latency", 32'(lat), 32'd27);
      take_result("t3");

      // T4: alignment clamp and overflow
      start_op(32'h4B80_0000, 32'h3F80_0000);
      wait_result(lat);
      check("t4a_result", result, 32'h4B80_0000);
      take_result("t4a");
      start_op(32'h7F7F_FFFF, 32'hFF7F_FFFF);
      wait_result(lat);
      check("t4b_result", result, 32'h7F80_0000);
      check("t4b_overflow", 32'(overflow), 32'd1);
      take_result("t4b");

      // T5: back-pressure holds result; new request while busy is dropped
      start_op(32'h4040_0000, 32'h3F80_0000);
      wait_result(lat);
      held = result;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = (i == 4);
         A = 32'h4120_0000; B = 32'h3F80_0000;
         check("t5_hold_result", result, held);
         check("t5_hold_valid", 32'(out_valid), 32'd1);
         check("t5_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk) in_valid = 1'b0;
      check("t5_value", held, 32'h4000_0000);
      take_result("t5");
      repeat (3) @(posedge clk);
      #1 check("t5_no_phantom", 32'(busy), 32'd0);

      // T6: reset during alignment aborts the operation
      start_op(32'h3F80_0000, 32'h3F7F_FFFF);
      @(negedge clk) rst_n = 1'b0;
      #1;
      check("t6_out_valid", 32'(out_valid), 32'd0);
      check("t6_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk) rst_n = 1'b1;
      run_and_check("t6_t1", 32'h4040_0000, 32'h3F80_0000);
      check("t6_t1_const", result, 32'h4000_0000);

      // Random operands, some near-equal to stress cancellation
      for (int i = 0; i < 60; i++) begin
         ra = {1'($urandom), 8'($urandom_range(130, 100)), 23'($urandom)};
         if (i % 3 == 0) rb = {1'($urandom), ra[30:23], ra[22:0] ^ 23'($urandom_range(255, 1))};
         else if (i % 3 == 1) rb = {1'($urandom), 8'($urandom_range(32'(ra[30:23]), 32'(ra[30:23]) - 3)), 23'($urandom)};
         else rb = {1'($urandom), 8'($urandom_range(131, 99)), 23'($urandom)};
         run_and_check("rand", ra, rb);
      end
      // Small exponents exercise the underflow path
      for (int i = 0; i < 10; i++) begin
         ra = {1'b0, 8'($urandom_range(4, 1)), 23'($urandom)};
         rb = {1'b0, ra[30:23], ra[22:0] ^ 23'($urandom_range(15, 1))};
         run_and_check("uflow", ra, rb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
